// File: rtl/rvv_vd_collector.sv
// Vector destination collector: merges per-lane element results into a VLEN-bit
// buffer under vl/tail/v0 policy, then issues one register-file write.
module rvv_vd_collector #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [4:0]                   vd_addr,
  input  logic [2:0]                   vsew,
  input  logic [10:0]                  vl,
  input  logic                         vm,
  input  logic                         instr_mask,
  input  logic [VLEN-1:0]              v0,
  input  logic [VLEN-1:0]              vd_old,
  input  logic [(1<<NB_LANES)-1:0]     lane_valid,
  input  logic [10*(1<<NB_LANES)-1:0]  lane_index,
  input  logic [64*(1<<NB_LANES)-1:0]  lane_data,
  input  logic                         alu_done,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [4:0]                   wb_addr,
  output logic [VLEN-1:0]              wb_data,
  output logic                         busy,
  output logic                         done
);
  localparam int LANES = 1 << NB_LANES;
  localparam int BW    = $clog2(VLEN);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic [VLEN-1:0]   buf_q, buf_d;
  logic [4:0]        addr_q;
  logic [2:0]        vsew_q;
  logic [10:0]       vl_q;
  logic              vm_q, imask_q;
  logic [VLEN-1:0]   v0_q;
  logic              accept;

  assign accept   = (state_q == IDLE) && start;
  assign wb_valid = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign wb_addr  = addr_q;
  assign wb_data  = buf_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (vl == 11'd0) done_d  = 1'b1;
          else             state_d = COLLECT;
        end
      end
      COLLECT: if (alu_done) state_d = WRITE;
      WRITE: begin
        if (wb_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes are merged in ascending order so the highest lane wins on a shared index.
  always_comb begin
    buf_d = buf_q;
    for (int l = 0; l < LANES; l++) begin
      logic [9:0]    idx;
      logic [63:0]   dat;
      logic [BW-1:0] bidx;
      logic [BW-1:0] off;
      int            lim;
      logic          wr;
      idx  = lane_index[l*10 +: 10];
      dat  = lane_data[l*64 +: 64];
      bidx = BW'(idx);
      off  = bidx << (int'(vsew_q) + 3);
      lim  = imask_q ? VLEN : (VLEN >> (int'(vsew_q) + 3));
      wr   = lane_valid[l] && (int'(idx) < lim) && ({1'b0, idx} < vl_q) &&
             (vm_q || v0_q[bidx]);
      if (wr) begin
        if (imask_q) begin
          buf_d[bidx] = dat[0];
        end else begin
          case (vsew_q)
            3'd0:    buf_d[off +: 8]  = dat[7:0];
            3'd1:    buf_d[off +: 16] = dat[15:0];
            3'd2:    buf_d[off +: 32] = dat[31:0];
            3'd3:    buf_d[off +: 64] = dat;
            default: buf_d = buf_d;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        buf_q  <= vd_old;
        addr_q <= vd_addr;
      end else if (state_q == COLLECT) begin
        buf_q  <= buf_d;
      end
    end
  end

  // Per-instruction context needs no reset; it is only read after a start.
  always_ff @(posedge clk) begin
    if (accept) begin
      vsew_q  <= vsew;
      vl_q    <= vl;
      vm_q    <= vm;
      imask_q <= instr_mask;
      v0_q    <= v0;
    end
  end
endmodule

// File: tb/tb_rvv_vd_collector.sv
// Scoreboard bench for rvv_vd_collector: directed plan cases plus randomized
// instructions checked against an element-level reference model.
module tb_rvv_vd_collector;
  localparam int VLEN = 128;
  localparam int NB_LANES = 1;
  localparam int LANES = 2;

  logic              clk = 1'b0;
  logic              reset, start, vm, instr_mask, alu_done, wb_ready;
  logic [4:0]        vd_addr;
  logic [2:0]        vsew;
  logic [10:0]       vl;
  logic [VLEN-1:0]   v0, vd_old;
  logic [LANES-1:0]  lane_valid;
  logic [10*LANES-1:0] lane_index;
  logic [64*LANES-1:0] lane_data;
  logic              wb_valid, busy, done;
  logic [4:0]        wb_addr;
  logic [VLEN-1:0]   wb_data;

  rvv_vd_collector #(.VLEN(VLEN), .NB_LANES(NB_LANES)) dut (
    .clk(clk), .reset(reset), .start(start), .vd_addr(vd_addr), .vsew(vsew),
    .vl(vl), .vm(vm), .instr_mask(instr_mask), .v0(v0), .vd_old(vd_old),
    .lane_valid(lane_valid), .lane_index(lane_index), .lane_data(lane_data),
    .alu_done(alu_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] addr; logic [VLEN-1:0] data; } exp_t;
  exp_t        sb[$];
  int          eq_idx[$];
  logic [63:0] eq_dat[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Expected register: start from vd_old, apply every presented element in order.
  function automatic logic [VLEN-1:0] model(input int sew, input int vlv, input logic vmv,
                                            input logic im, input logic [VLEN-1:0] v0v,
                                            input logic [VLEN-1:0] oldv);
    logic [VLEN-1:0] r;
    int esz, lim, i;
    r   = oldv;
    esz = 8 << sew;
    lim = im ? VLEN : VLEN / esz;
    for (int k = 0; k < eq_idx.size(); k++) begin
      i = eq_idx[k];
      if (i < lim && i < vlv && (vmv || v0v[i])) begin
        if (im) r[i] = eq_dat[k][0];
        else for (int b = 0; b < esz; b++) r[i*esz + b] = eq_dat[k][b];
      end
    end
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%h data=%h required no write", wb_addr, wb_data);
        end else begin
          e = sb.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_addr", {123'd0, wb_addr}, {123'd0, e.addr});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic scramble_ctx();
    vd_addr = 5'($urandom); vsew = 3'($urandom); vl = 11'($urandom);
    vm = 1'($urandom); instr_mask = 1'($urandom);
    v0 = {$urandom, $urandom, $urandom, $urandom};
    vd_old = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_txn(input logic [4:0] addr, input int sew, input int vlv, input logic vmv,
                         input logic im, input logic [VLEN-1:0] v0v, input logic [VLEN-1:0] oldv,
                         input int rwait, input bit start_in_write);
    int k, pat;
    logic [VLEN-1:0] d0;
    logic [4:0] a0;
    @(posedge clk); #1;
    vd_addr = addr; vsew = 3'(sew); vl = 11'(vlv); vm = vmv; instr_mask = im;
    v0 = v0v; vd_old = oldv; start = 1'b1;
    if (vlv != 0) sb.push_back('{addr, model(sew, vlv, vmv, im, v0v, oldv)});
    @(posedge clk); #1;
    start = 1'b0;
    scramble_ctx();
    if (vlv == 0) begin
      chk("vl0_done", done, 1'b1);
      chk("vl0_wb_valid", wb_valid, 1'b0);
      chk("vl0_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("vl0_done_pulse", done, 1'b0);
    end else begin
      chk("collect_busy", busy, 1'b1);
      k = 0;
      forever begin
        lane_valid = '0;
        lane_index = 20'($urandom);
        lane_data  = {$urandom, $urandom, $urandom, $urandom};
        pat = $urandom_range(0, 3);
        for (int l = 0; l < LANES; l++) begin
          if (pat[l] && k < eq_idx.size()) begin
            lane_valid[l] = 1'b1;
            lane_index[l*10 +: 10] = 10'(eq_idx[k]);
            lane_data[l*64 +: 64]  = eq_dat[k];
            k++;
          end
        end
        alu_done = (k == eq_idx.size());
        @(posedge clk); #1;
        if (alu_done) break;
      end
      alu_done = 1'b0;
      lane_valid = 2'($urandom);
      chk("write_wb_valid", wb_valid, 1'b1);
      d0 = wb_data;
      a0 = wb_addr;
      for (int c = 0; c < rwait; c++) begin
        start = start_in_write && (c == 1);
        vd_addr = ~addr;
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_wb_valid", wb_valid, 1'b1);
        chk("hold_wb_data", wb_data, d0);
        chk("hold_wb_addr", {123'd0, wb_addr}, {123'd0, a0});
      end
      wb_ready = 1'b1;
      @(posedge clk); #1;
      wb_ready = 1'b0;
      lane_valid = '0;
      chk("hs_done", done, 1'b1);
      chk("hs_wb_valid", wb_valid, 1'b0);
      chk("hs_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("done_single", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
    eq_idx.delete();
    eq_dat.delete();
  endtask

  task automatic add_el(input int i, input logic [63:0] d);
    eq_idx.push_back(i);
    eq_dat.push_back(d);
  endtask

  initial begin : stim
    int sew, esz, lim, n, vlv, j, tmp;
    logic im;
    logic [63:0] td;
    reset = 1'b1; start = 1'b0; alu_done = 1'b0; wb_ready = 1'b0;
    lane_valid = '0; lane_index = '0; lane_data = '0;
    vd_addr = '0; vsew = '0; vl = '0; vm = 1'b1; instr_mask = 1'b0; v0 = '0; vd_old = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wb_addr", {123'd0, wb_addr}, '0);
    chk("rst_wb_data", wb_data, '0);
    reset = 1'b0;

    // Basic SEW=32
    add_el(0, 64'h11111111); add_el(1, 64'h22222222);
    add_el(2, 64'h33333333); add_el(3, 64'h44444444);
    run_txn(5'd7, 2, 4, 1'b1, 1'b0, '0, '0, 0, 1'b0);

    // Tail undisturbed
    for (int i = 0; i < 4; i++) add_el(i, 64'(i + 1));
    run_txn(5'd3, 0, 3, 1'b1, 1'b0, '0, {VLEN{1'b1}}, 1, 1'b0);

    // v0 masking
    for (int i = 0; i < 4; i++) add_el(i, 64'hAAAAAAAA);
    run_txn(5'd9, 2, 4, 1'b0, 1'b0, 128'b1010, '0, 0, 1'b0);

    // Mask-producing op
    for (int i = 0; i < 16; i++) begin
      td = {$urandom, $urandom};
      td[0] = (i % 2 == 0);
      add_el(i, td);
    end
    run_txn(5'd12, 2, 16, 1'b1, 1'b1, '0, '0, 0, 1'b0);

    // Backpressure with start during WRITE
    for (int i = 0; i < 4; i++) add_el(i, {$urandom, $urandom});
    run_txn(5'd21, 2, 4, 1'b1, 1'b0, '0, {$urandom, $urandom, $urandom, $urandom}, 5, 1'b1);

    // vl = 0
    run_txn(5'd4, 1, 0, 1'b1, 1'b0, '0, '1, 0, 1'b0);

    // Reset while collecting
    @(posedge clk); #1;
    vd_addr = 5'd30; vsew = 3'd2; vl = 11'd4; vm = 1'b1; instr_mask = 1'b0;
    vd_old = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lane_valid = 2'b11; lane_index = {10'd1, 10'd0}; lane_data = '1;
    @(posedge clk); #1;
    lane_valid = 2'b11; alu_done = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; alu_done = 1'b0; lane_valid = '0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_wb_valid", wb_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_wb_data", wb_data, '0);
    wb_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wb_ready = 1'b0;
    chk("abort_idle", busy, 1'b0);

    // Randomized instructions
    for (int t = 0; t < 40; t++) begin
      sew = $urandom_range(0, 3);
      esz = 8 << sew;
      im  = ($urandom_range(0, 3) == 0);
      lim = im ? VLEN : VLEN / esz;
      n   = $urandom_range(1, lim + 2);
      vlv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, lim + 3);
      for (int i = 0; i < n; i++) eq_idx.push_back(i);
      for (int i = n - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = eq_idx[i]; eq_idx[i] = eq_idx[j]; eq_idx[j] = tmp;
      end
      for (int i = 0; i < n; i++) eq_dat.push_back({$urandom, $urandom});
      repeat ($urandom_range(0, 3)) begin
        eq_idx.push_back(eq_idx[$urandom_range(0, n - 1)]);
        eq_dat.push_back({$urandom, $urandom});
      end
      if (vlv == 0) begin
        eq_idx.delete();
        eq_dat.delete();
      end
      run_txn(5'($urandom), sew, vlv, 1'($urandom), im,
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 3), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 128'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
